// File: rtl/multi_digit_display_pkg.sv
// Shared constants for the multiplexed display: segment patterns for hex digits
// and the largest supported digit count.
package multi_digit_display_pkg;

    localparam int MAX_DIGITS = 8;

    // Patterns are {g,f,e,d,c,b,a}, a segment lights when its bit is 1
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [7:0] seg_pattern(input logic [3:0] nibble, input logic dp);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return {dp, seg};
    endfunction

endpackage

// File: rtl/multi_digit_display_decoder.sv
// Combinational hex-to-seven-segment decoder shared by all digits of the display.
module multi_digit_display_decoder
    import multi_digit_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pins
);

    always_comb begin
        pins = seg_pattern(nibble, dp);
    end

endmodule

// File: rtl/multi_digit_display.sv
// Time-multiplexed hex display driver with frame-synchronous loading,
// leading-zero blanking and PWM brightness control.
module multi_digit_display
    import multi_digit_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 120,
    parameter int PWM_BITS       = 4,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_mask,
    input  logic                  load,
    input  logic                  blank_zeros,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     select_digit,
    output logic [7:0]            display_pins,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic              SEL_INV    = (SEL_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{SEL_INV}};
    localparam logic [7:0]        PINS_RESET = seg_pattern(4'h0, 1'b0);

    logic [CNT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pwm;

    logic                pend_flag;
    logic [4*DIGITS-1:0] pend_number;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_mask;
    logic                pend_blank;

    logic [4*DIGITS-1:0] act_number;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_mask;
    logic                act_blank;

    logic                slot_tick;
    logic                frame_wrap;
    logic [DIGITS-1:0]   lead_zero;
    logic                above_zero;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_mask;
    logic                cur_lead_zero;
    logic                blanked;
    logic                lit;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          dec_pins;

    assign slot_tick  = (slot_cnt == CNT_LAST);
    assign frame_wrap = slot_tick && (idx == IDX_LAST);

    // lead_zero[i]: digit i and every digit above it show zero with no point
    always_comb begin
        above_zero = 1'b1;
        lead_zero  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero && (act_number[4*i +: 4] == 4'h0) && !act_dp[i];
            lead_zero[i] = above_zero;
        end
    end

    always_comb begin
        cur_nibble    = 4'h0;
        cur_dp        = 1'b0;
        cur_mask      = 1'b0;
        cur_lead_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx) begin
                cur_nibble    = act_number[4*i +: 4];
                cur_dp        = act_dp[i];
                cur_mask      = act_mask[i];
                cur_lead_zero = lead_zero[i];
            end
        end
        blanked  = act_blank && (idx != '0) && cur_lead_zero;
        lit      = cur_mask && !blanked && (pwm <= brightness);
        sel_next = lit ? (DIGITS'(1) << idx) : '0;
    end

    multi_digit_display_decoder u_decoder (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .pins   (dec_pins)
    );

    // A load landing on the frame boundary goes straight to the active copy
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt     <= '0;
            idx          <= '0;
            pwm          <= '0;
            pend_flag    <= 1'b0;
            pend_number  <= '0;
            pend_dp      <= '0;
            pend_mask    <= '0;
            pend_blank   <= 1'b0;
            act_number   <= '0;
            act_dp       <= '0;
            act_mask     <= '0;
            act_blank    <= 1'b0;
            select_digit <= SEL_OFF;
            display_pins <= PINS_RESET;
            frame_done   <= 1'b0;
        end else begin
            pwm          <= pwm + PWM_BITS'(1);
            slot_cnt     <= slot_tick ? '0 : slot_cnt + CNT_W'(1);
            if (slot_tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            frame_done   <= frame_wrap;
            select_digit <= sel_next ^ SEL_OFF;
            display_pins <= dec_pins;

            if (load) begin
                pend_number <= number;
                pend_dp     <= dp;
                pend_mask   <= digit_mask;
                pend_blank  <= blank_zeros;
            end

            if (frame_wrap) begin
                if (load) begin
                    act_number <= number;
                    act_dp     <= dp;
                    act_mask   <= digit_mask;
                    act_blank  <= blank_zeros;
                end else if (pend_flag) begin
                    act_number <= pend_number;
                    act_dp     <= pend_dp;
                    act_mask   <= pend_mask;
                    act_blank  <= pend_blank;
                end
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_flag <= 1'b1;
            end
        end
    end

endmodule
